// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port data RAM between the CPU
// pipeline and a debug/DMA port, with a starvation guard for the DMA side.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/addr/we/wd            CPU request (byte addr, unshifted we/wd)
//   cpu_gnt, cpu_stall            CPU grant this cycle, pipeline stall
//   cpu_rvalid, cpu_rdata         CPU read response (held when not valid)
//   dma_*                         same set for the debug/DMA requester
//   ram_wea/addra/dina/douta      RAM port A (1-cycle read latency)
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_wd,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [3:0]  dma_we,
    input  logic [31:0] dma_wd,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [3:0]  ram_wea,
    output logic [29:0] ram_addra,
    output logic [31:0] ram_dina,
    input  logic [31:0] ram_douta
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_e;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    owner_e      owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] cpu_hold_q, dma_hold_q;

    logic        starve_hit;
    logic [31:0] sel_addr;
    logic [3:0]  sel_we;
    logic [31:0] sel_wd;

    // DMA has waited STARVE_MAX CPU grants: it wins this cycle.
    assign starve_hit = dma_req && (starve_q == SMAX);

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            cpu_gnt = cpu_req && !starve_hit;
            dma_gnt = dma_req && !cpu_gnt;
        end
    end

    assign cpu_stall = cpu_req && !cpu_gnt;

    // With no grant the CPU address is still presented to the RAM.
    always_comb begin
        sel_addr = cpu_addr;
        sel_we   = cpu_we;
        sel_wd   = cpu_wd;
        if (dma_gnt) begin
            sel_addr = dma_addr;
            sel_we   = dma_we;
            sel_wd   = dma_wd;
        end
    end

    always_comb begin
        ram_addra = sel_addr[31:2];
        ram_dina  = sel_wd << {sel_addr[1:0], 3'b000};
        ram_wea   = 4'b0000;
        if (cpu_gnt || dma_gnt) begin
            ram_wea = sel_we << sel_addr[1:0];
        end
    end

    // Read owner: tags the RAM response that arrives next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (cpu_gnt && (cpu_we == 4'b0000)) begin
            owner_d = OWN_CPU;
        end else if (dma_gnt && (dma_we == 4'b0000)) begin
            owner_d = OWN_DMA;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (dma_gnt || !dma_req) begin
            starve_d = 4'd0;
        end else if (cpu_gnt && (starve_q != SMAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Reset kills an in-flight response in the same cycle it is asserted.
    assign cpu_rvalid = !rst && (owner_q == OWN_CPU);
    assign dma_rvalid = !rst && (owner_q == OWN_DMA);

    always_comb begin
        cpu_rdata = cpu_hold_q;
        dma_rdata = dma_hold_q;
        if (rst) begin
            cpu_rdata = 32'd0;
            dma_rdata = 32'd0;
        end else begin
            if (cpu_rvalid) cpu_rdata = ram_douta;
            if (dma_rvalid) dma_rdata = ram_douta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            starve_q   <= 4'd0;
            cpu_hold_q <= 32'd0;
            dma_hold_q <= 32'd0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            if (cpu_rvalid) cpu_hold_q <= ram_douta;
            if (dma_rvalid) dma_hold_q <= ram_douta;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors, read responses
// checked by a scoreboard monitor, grant/RAM outputs checked per cycle.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [3:0]  cpu_we = '0;
    logic [31:0] cpu_wd = '0;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req = 1'b0;
    logic [31:0] dma_addr = '0;
    logic [3:0]  dma_we = '0;
    logic [31:0] dma_wd = '0;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic [3:0]  ram_wea;
    logic [29:0] ram_addra;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta = '0;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    typedef struct packed {
        logic        dma;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] last_c = '0;
    logic [31:0] last_d = '0;

    dmem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wd(cpu_wd), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we),
        .dma_wd(dma_wd), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_douta(ram_douta)
    );

    always #5 clk = ~clk;

    // RAM model: read word at address a returns 0xD000_0000 | a.
    always @(posedge clk) ram_douta <= 32'hD000_0000 | {2'b00, ram_addra};

    function automatic logic [31:0] rd(input logic [31:0] byte_addr);
        return 32'hD000_0000 | {2'b00, byte_addr[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r,
                       input logic cr, input logic [31:0] ca,
                       input logic [3:0] cw, input logic [31:0] cwd,
                       input logic dr, input logic [31:0] da,
                       input logic [3:0] dw, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        rst = r;
        cpu_req = cr; cpu_addr = ca; cpu_we = cw; cpu_wd = cwd;
        dma_req = dr; dma_addr = da; dma_we = dw; dma_wd = dwd;
        @(negedge clk);
    endtask

    task automatic gnt_chk(input string name, input logic cg, input logic dg);
        chk({name, "_cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, cg});
        chk({name, "_dma_gnt"}, {31'd0, dma_gnt}, {31'd0, dg});
    endtask

    task automatic push(input logic is_dma, input logic [31:0] d);
        exp_t e;
        e.dma = is_dma;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: pops on every response, checks hold values otherwise.
    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
                chk("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
                chk("rst_cpu_rdata", cpu_rdata, 32'd0);
                chk("rst_dma_rdata", dma_rdata, 32'd0);
                last_c = '0;
                last_d = '0;
            end else begin
                if (cpu_rvalid || dma_rvalid) begin
                    if (cpu_rvalid && dma_rvalid) begin
                        chk("both_rvalid", 32'd1, 32'd0);
                    end
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rvalid", {30'd0, dma_rvalid, cpu_rvalid}, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("resp_port_is_dma", {31'd0, dma_rvalid}, {31'd0, e.dma});
                        if (e.dma) begin
                            chk("dma_rdata", dma_rdata, e.data);
                            last_d = e.data;
                        end else begin
                            chk("cpu_rdata", cpu_rdata, e.data);
                            last_c = e.data;
                        end
                    end
                end
                if (!cpu_rvalid) chk("cpu_rdata_hold", cpu_rdata, last_c);
                if (!dma_rvalid) chk("dma_rdata_hold", dma_rdata, last_d);
            end
        end
    end

    initial begin
        // Reset with requests asserted: grants and write enables forced off.
        cyc(1, 1, 32'h10, 4'hF, 32'h1, 1, 32'h20, 4'hF, 32'h2);
        started = 1'b1;
        gnt_chk("rst", 0, 0);
        chk("rst_wea", {28'd0, ram_wea}, 32'd0);
        cyc(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);

        // CPU read 0x10
        cyc(0, 1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
        gnt_chk("cpu_rd", 1, 0);
        chk("cpu_rd_addra", {2'd0, ram_addra}, 32'h4);
        chk("cpu_rd_wea", {28'd0, ram_wea}, 32'd0);
        chk("cpu_rd_stall", {31'd0, cpu_stall}, 32'd0);
        push(0, rd(32'h10));

        // CPU store byte at 0x3
        cyc(0, 1, 32'h3, 4'b0001, 32'hAB, 0, 32'h0, 4'h0, 32'h0);
        gnt_chk("cpu_sb", 1, 0);
        chk("cpu_sb_wea", {28'd0, ram_wea}, 32'h8);
        chk("cpu_sb_dina", ram_dina, 32'hAB00_0000);
        chk("cpu_sb_addra", {2'd0, ram_addra}, 32'h0);

        // DMA halfword store at 0x6
        cyc(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h6, 4'b0011, 32'h1234);
        gnt_chk("dma_sh", 0, 1);
        chk("dma_sh_wea", {28'd0, ram_wea}, 32'hC);
        chk("dma_sh_dina", ram_dina, 32'h1234_0000);
        chk("dma_sh_addra", {2'd0, ram_addra}, 32'h1);

        // DMA read 0x20 then CPU read 0x40: responses return to owners.
        cyc(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h20, 4'h0, 32'h0);
        chk("after_sh_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("after_sh_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
        gnt_chk("dma_rd", 0, 1);
        chk("dma_rd_addra", {2'd0, ram_addra}, 32'h8);
        push(1, rd(32'h20));
        cyc(0, 1, 32'h40, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
        gnt_chk("cpu_rd40", 1, 0);
        chk("n1_dma_rvalid", {31'd0, dma_rvalid}, 32'd1);
        push(0, rd(32'h40));

        // Idle: no grant, CPU address presented, no write.
        cyc(0, 0, 32'h30, 4'hF, 32'h0, 0, 32'h0, 4'h0, 32'h0);
        chk("n2_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        gnt_chk("idle", 0, 0);
        chk("idle_addra", {2'd0, ram_addra}, 32'hC);
        chk("idle_wea", {28'd0, ram_wea}, 32'd0);

        // Starvation guard: both held, CPU x4 then DMA, then CPU again.
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 32'h100, 4'h0, 32'h0, 1, 32'h200, 4'h0, 32'h0);
            if (i == 4) begin
                gnt_chk($sformatf("starve%0d", i), 0, 1);
                chk("starve_stall", {31'd0, cpu_stall}, 32'd1);
                push(1, rd(32'h200));
            end else begin
                gnt_chk($sformatf("starve%0d", i), 1, 0);
                chk($sformatf("starve_stall%0d", i), {31'd0, cpu_stall}, 32'd0);
                push(0, rd(32'h100));
            end
        end
        cyc(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);

        // Build starve count to 2, reset mid-read; response is dropped.
        cyc(0, 1, 32'h50, 4'h0, 32'h0, 1, 32'h60, 4'h0, 32'h0);
        gnt_chk("pre_rst0", 1, 0);
        push(0, rd(32'h50));
        cyc(0, 1, 32'h54, 4'h0, 32'h0, 1, 32'h60, 4'h0, 32'h0);
        gnt_chk("pre_rst1", 1, 0);
        cyc(1, 1, 32'h58, 4'hF, 32'h0, 1, 32'h60, 4'h0, 32'h0);
        gnt_chk("mid_rst", 0, 0);
        chk("mid_rst_wea", {28'd0, ram_wea}, 32'd0);

        // After reset the count restarts at 0: four CPU grants, then DMA.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 32'h70, 4'h0, 32'h0, 1, 32'h80, 4'h0, 32'h0);
            if (i == 0) begin
                chk("post_rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
            end
            if (i == 4) begin
                gnt_chk("post_rst4", 0, 1);
                push(1, rd(32'h80));
            end else begin
                gnt_chk($sformatf("post_rst%0d", i), 1, 0);
                push(0, rd(32'h70));
            end
        end
        cyc(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
        cyc(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
        cyc(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
